// File: rtl/mvp_pkg.sv
// Package shared by the mvp result-collection logic.
//   lane_a(n)   : index width A = $clog2(n)
//   ps_width(n) : width of one signed partial-sum lane, A+2
//   state_t     : collector FSM encoding (ST_IDLE / ST_ACCUM / ST_DRAIN)
//   sext64      : sign-extend a w-bit value held in the low bits of a 64-bit word
package mvp_pkg;

  function automatic int lane_a(input int n);
    return $clog2(n);
  endfunction

  function automatic int ps_width(input int n);
    return $clog2(n) + 2;
  endfunction

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ACCUM = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;

  // w must be a constant in 1..64; bits above w in v are ignored.
  function automatic logic signed [63:0] sext64(input logic [63:0] v, input int unsigned w);
    logic signed [63:0] t;
    t = signed'(v << (64 - w));
    return t >>> (64 - w);
  endfunction

endpackage

// File: rtl/mvp_collect_lane.sv
// One accumulator of the mvp collector: load, or shift-and-add, one signed
// partial sum per accepted plane, optionally negated for the sign plane.
// Build option: define MVP_COLLECT_SAT_EN to clamp each update to the
// ACC_W-bit two's-complement range; otherwise updates wrap modulo 2^ACC_W.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   en_i        : a plane is accepted this cycle
//   shift_i     : 1 = acc <- 2*acc + term, 0 = acc <- term (first plane)
//   neg_i       : subtract the lane value instead of adding it
//   s_i         : PS_W-bit signed partial sum of this row
//   acc_next_o  : next-state of the accumulator (equals the stored value when en_i=0)
module mvp_collect_lane
  import mvp_pkg::*;
#(
  parameter int PS_W  = 8,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             shift_i,
  input  logic             neg_i,
  input  logic [PS_W-1:0]  s_i,
  output logic [ACC_W-1:0] acc_next_o
);

  // Two guard bits: 2*acc spans ACC_W+1 bits and the added term cannot push
  // it past ACC_W+2, so the sum never overflows before reduction.
  localparam int EXT_W = ACC_W + 2;

`ifdef MVP_COLLECT_SAT_EN
  localparam logic signed [EXT_W-1:0] SAT_MAX = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN = {3'b111, {(ACC_W-1){1'b0}}};
`endif

  logic [ACC_W-1:0]        acc_q, acc_d;
  logic signed [EXT_W-1:0] lane_ext, term, base, sum;
  logic [ACC_W-1:0]        res;

  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a value on
    // every path (defaults first), otherwise synthesis infers a latch.
    res      = '0;
    lane_ext = EXT_W'(sext64(64'(s_i), PS_W));
    term     = neg_i ? -lane_ext : lane_ext;
    base     = shift_i ? ({{2{acc_q[ACC_W-1]}}, acc_q} <<< 1) : '0;
    sum      = base + term;
`ifdef MVP_COLLECT_SAT_EN
    if (sum > SAT_MAX)      res = ACC_W'(SAT_MAX);
    else if (sum < SAT_MIN) res = ACC_W'(SAT_MIN);
    else                    res = ACC_W'(sum);
`else
    res = ACC_W'(sum);
`endif
    acc_d = en_i ? res : acc_q;
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of block ordering.
  // NOTE: the accumulator is a plain register (not a RAM), so it is reset;
  // a reset mid-product must leave no stale partial sum behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  // The top takes the next-state so the first result is ready in the same
  // cycle the final plane lands.
  assign acc_next_o = acc_d;

endmodule

// File: rtl/mvp_collect.sv
// mvp_collect: result-side consumer of the matrix-vector product array.
// Accepts one bit-plane of n signed partial sums per beat, accumulates the
// planes MSB-first by shift-add into n accumulators, then drains the n
// dot-products as a valid/ready stream, one per cycle.
// Build option: MVP_COLLECT_SAT_EN (saturating accumulators, see lane).
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   s_valid/s_ready          : plane beat handshake (s_ready low while draining)
//   s_neg                    : plane is the negative (sign) plane: subtract
//   s_last                   : final plane of the product
//   S                        : n lanes of A+2 bits, lane i at S[i*(A+2) +: A+2]
//   m_valid/m_ready          : result handshake
//   m_data, m_idx, m_last    : result value, its row index, high on row n-1
// n must be at least 2.
module mvp_collect
  import mvp_pkg::*;
#(
  parameter int n     = 64,
  parameter int ACC_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic                      s_neg,
  input  logic                      s_last,
  input  logic [n*ps_width(n)-1:0]  S,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [ACC_W-1:0]          m_data,
  output logic [lane_a(n)-1:0]      m_idx,
  output logic                      m_last
);

  localparam int PS_W  = ps_width(n);
  localparam int IDX_W = lane_a(n);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(n - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             m_valid_q, m_valid_d;
  logic             m_last_q, m_last_d;
  logic [ACC_W-1:0] m_data_q, m_data_d;
  logic             beat, lane_shift;
  logic [ACC_W-1:0] acc_next [n];

  assign s_ready    = (state_q != ST_DRAIN);
  assign beat       = s_valid & s_ready;
  // Only the first plane of a product loads; later planes shift-add.
  assign lane_shift = (state_q == ST_ACCUM);

  for (genvar i = 0; i < n; i++) begin : g_lane
    mvp_collect_lane #(
      .PS_W  (PS_W),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .en_i       (beat),
      .shift_i    (lane_shift),
      .neg_i      (s_neg),
      .s_i        (S[i*PS_W +: PS_W]),
      .acc_next_o (acc_next[i])
    );
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (beat)                       state_d = s_last ? ST_DRAIN : ST_ACCUM;
      ST_ACCUM: if (beat && s_last)             state_d = ST_DRAIN;
      ST_DRAIN: if (m_ready && idx_q == LAST_IDX) state_d = ST_IDLE;
      default:                                  state_d = ST_IDLE;
    endcase

    // Index restarts at 0 on entry to DRAIN and returns to 0 when leaving it.
    idx_d = '0;
    if (state_q == ST_DRAIN && state_d == ST_DRAIN)
      idx_d = m_ready ? idx_q + IDX_W'(1) : idx_q;

    m_valid_d = (state_d == ST_DRAIN);
    m_last_d  = m_valid_d && (idx_d == LAST_IDX);
    // Accumulators are frozen during DRAIN, so the next-state equals the
    // stored value there; on entry it already holds the final plane.
    m_data_d  = m_valid_d ? acc_next[idx_d] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_data_q  <= m_data_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_idx   = idx_q;
  assign m_last  = m_last_q;
  assign m_data  = m_data_q;

endmodule

// File: tb/tb_mvp_collect.sv
// Directed self-checking bench for mvp_collect with n=4, ACC_W=8
// (lanes are 4-bit signed, -8..7).
module tb_mvp_collect;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid, s_ready, s_neg, s_last;
  logic [15:0] S;
  logic        m_valid, m_ready, m_last;
  logic [7:0]  m_data;
  logic [1:0]  m_idx;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mvp_collect #(.n(4), .ACC_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_neg   (s_neg),
    .s_last  (s_last),
    .S       (S),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_idx   (m_idx),
    .m_last  (m_last)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pack4(input int a, input int b, input int c, input int d);
    return {4'(d), 4'(c), 4'(b), 4'(a)};
  endfunction

  // Called at a negedge: presents one beat, returns at the next negedge
  // with s_valid still high (caller decides whether a gap follows).
  task automatic send(input logic [15:0] lanes, input logic neg, input logic last);
    s_valid = 1'b1;
    S       = lanes;
    s_neg   = neg;
    s_last  = last;
    @(negedge clk);
  endtask

  // Called at the negedge right after the final plane was accepted, with
  // m_ready held high: expects four back-to-back results, then idle.
  task automatic drain_check(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] exp [4];
    exp = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s[%0d] m_valid", tag, i), 32'(m_valid), 32'd1);
      check($sformatf("%s[%0d] m_idx", tag, i),   32'(m_idx),   32'(i));
      check($sformatf("%s[%0d] m_data", tag, i),  32'(m_data),  32'(exp[i]));
      check($sformatf("%s[%0d] m_last", tag, i),  32'(m_last),  32'(i == 3));
      check($sformatf("%s[%0d] s_ready", tag, i), 32'(s_ready), 32'd0);
      @(negedge clk);
    end
    check($sformatf("%s end m_valid", tag), 32'(m_valid), 32'd0);
    check($sformatf("%s end s_ready", tag), 32'(s_ready), 32'd1);
    check($sformatf("%s end m_idx", tag),   32'(m_idx),   32'd0);
  endtask

  initial begin
    rst     = 1'b1;
    s_valid = 1'b0;
    s_neg   = 1'b0;
    s_last  = 1'b0;
    S       = '0;
    m_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst m_valid", 32'(m_valid), 32'd0);
    check("rst m_data",  32'(m_data),  32'd0);
    check("rst m_idx",   32'(m_idx),   32'd0);
    check("rst m_last",  32'(m_last),  32'd0);
    check("rst s_ready", 32'(s_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // 1: single-beat product
    send(pack4(3, 3, 3, 3), 1'b0, 1'b1);
    s_valid = 1'b0;
    drain_check("t1", 8'd3, 8'd3, 8'd3, 8'd3);

    // 2: negative plane then positive plane: (-1<<1)+2 = 0
    send(pack4(1, 1, 1, 1), 1'b1, 1'b0);
    send(pack4(2, 2, 2, 2), 1'b0, 1'b1);
    s_valid = 1'b0;
    drain_check("t2a", 8'd0, 8'd0, 8'd0, 8'd0);
    send(pack4(5, -6, 0, 7), 1'b0, 1'b1);
    s_valid = 1'b0;
    drain_check("t2b", 8'd5, 8'hFA, 8'd0, 8'd7);
    // Sign plane alone, including negation of the most negative lane value
    send(pack4(-8, 7, -1, 0), 1'b1, 1'b1);
    s_valid = 1'b0;
    drain_check("t2c", 8'd8, 8'hF9, 8'd1, 8'd0);

    // 3: backpressure at idx 2 with ignored s_valid pulses
    send(pack4(1, 2, 3, 4), 1'b0, 1'b1);
    s_valid = 1'b0;
    check("t3 idx0", 32'(m_idx), 32'd0);
    @(negedge clk);
    check("t3 idx1", 32'(m_idx), 32'd1);
    @(negedge clk);
    check("t3 idx2",  32'(m_idx),  32'd2);
    check("t3 data2", 32'(m_data), 32'd3);
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = (i % 2 == 0);
      S       = pack4(7, 7, 7, 7);
      s_last  = 1'b1;
      @(negedge clk);
      check($sformatf("t3 hold%0d m_valid", i), 32'(m_valid), 32'd1);
      check($sformatf("t3 hold%0d m_idx", i),   32'(m_idx),   32'd2);
      check($sformatf("t3 hold%0d m_data", i),  32'(m_data),  32'd3);
      check($sformatf("t3 hold%0d s_ready", i), 32'(s_ready), 32'd0);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    check("t3 idx3",  32'(m_idx),  32'd3);
    check("t3 data3", 32'(m_data), 32'd4);
    check("t3 last3", 32'(m_last), 32'd1);
    @(negedge clk);
    check("t3 end m_valid", 32'(m_valid), 32'd0);
    check("t3 end s_ready", 32'(s_ready), 32'd1);

    // 4a: six positive planes of {7,-7,1,-8}; overflow after plane 5,
    // a clamped value must carry into plane 6 unchanged
    for (int p = 0; p < 6; p++) send(pack4(7, -7, 1, -8), 1'b0, p == 5);
    s_valid = 1'b0;
`ifdef MVP_COLLECT_SAT_EN
    drain_check("t4a", 8'd127, 8'h80, 8'd63, 8'h80);
`else
    drain_check("t4a", 8'hB9, 8'd71, 8'd63, 8'd8);
`endif
    // 4b: five negated planes of {7,-7,1,-8}
    for (int p = 0; p < 5; p++) send(pack4(7, -7, 1, -8), 1'b1, p == 4);
    s_valid = 1'b0;
`ifdef MVP_COLLECT_SAT_EN
    drain_check("t4b", 8'h80, 8'd127, 8'hE1, 8'd127);
`else
    drain_check("t4b", 8'd39, 8'hD9, 8'hE1, 8'hF8);
`endif

    // 5a: asynchronous reset mid-DRAIN at idx 2
    send(pack4(1, 2, 3, 4), 1'b0, 1'b1);
    s_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t5 pre idx", 32'(m_idx), 32'd2);
    #2 rst = 1'b1;
    #1;
    check("t5 rst m_valid", 32'(m_valid), 32'd0);
    check("t5 rst m_idx",   32'(m_idx),   32'd0);
    check("t5 rst m_data",  32'(m_data),  32'd0);
    check("t5 rst m_last",  32'(m_last),  32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t5 post s_ready", 32'(s_ready), 32'd1);
    check("t5 post m_valid", 32'(m_valid), 32'd0);
    send(pack4(2, -3, 4, 1), 1'b0, 1'b1);
    s_valid = 1'b0;
    drain_check("t5a", 8'd2, 8'hFD, 8'd4, 8'd1);

    // 5b: reset mid-ACCUM; the next plane must load, not shift-add
    send(pack4(3, 3, 3, 3), 1'b0, 1'b0);
    s_valid = 1'b0;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    check("t5b m_valid", 32'(m_valid), 32'd0);
    send(pack4(2, 2, -2, 0), 1'b0, 1'b1);
    s_valid = 1'b0;
    drain_check("t5b", 8'd2, 8'd2, 8'hFE, 8'd0);

    // 6: three planes gap-free, then with idle cycles in between
    send(pack4(1, -2, 3, -4), 1'b0, 1'b0);
    send(pack4(5, 6, -7, 0),  1'b0, 1'b0);
    send(pack4(2, 2, 2, 2),   1'b1, 1'b1);
    s_valid = 1'b0;
    drain_check("t6 nogap", 8'd12, 8'd2, 8'hFC, 8'hEE);
    send(pack4(1, -2, 3, -4), 1'b0, 1'b0);
    s_valid = 1'b0;
    S       = pack4(7, 7, 7, 7);
    @(negedge clk);
    send(pack4(5, 6, -7, 0),  1'b0, 1'b0);
    s_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    send(pack4(2, 2, 2, 2),   1'b1, 1'b1);
    s_valid = 1'b0;
    drain_check("t6 gap", 8'd12, 8'd2, 8'hFC, 8'hEE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
